// File: rtl/ram_scanout.sv
// rtl/ram_scanout.sv - scans the loaded byte RAM once per frame into a stream of RGB565 pixels
module ram_scanout #(
    parameter int BYTES       = 12288,
    parameter int ADDR_W      = 14,
    parameter int LINE_PIXELS = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ram_ready,
    input  logic              frame_start,
    output logic [ADDR_W-1:0] address,
    input  logic [15:0]       dataout,
    output logic [15:0]       px_data,
    output logic              px_valid,
    input  logic              px_ready,
    output logic              px_eol,
    output logic              px_last,
    output logic              busy,
    output logic              frame_done
);

    localparam int PIXELS = BYTES / 2;
    localparam int LW     = (LINE_PIXELS > 1) ? $clog2(LINE_PIXELS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W:0]   byte_cnt;
    logic [ADDR_W-1:0] pix_cnt;
    logic [LW-1:0]     line_cnt;
    logic              rd_vld, rd_odd;
    logic [7:0]        hi_byte;
    logic [1:0]        asm_cnt;
    logic [17:0]       fifo_mem [2];
    logic              wr_ptr, rd_ptr;
    logic [1:0]        fifo_cnt;
    logic [17:0]       head;
    logic              issue, push, pop, done_nxt, start;
    logic              last_byte;
    logic              unused_hi;

    assign unused_hi = ^dataout[15:8];

    assign head      = fifo_mem[rd_ptr];
    assign px_valid  = (fifo_cnt != 2'd0);
    assign px_data   = px_valid ? head[15:0] : 16'd0;
    assign px_eol    = px_valid & head[16];
    assign px_last   = px_valid & head[17];
    assign busy      = (state != S_IDLE);
    assign address   = byte_cnt[ADDR_W-1:0];
    assign push      = rd_vld & rd_odd;
    assign pop       = px_valid & px_ready;
    assign last_byte = (byte_cnt == (ADDR_W+1)'(BYTES - 1));
    assign start     = (state == S_IDLE) & frame_start & ram_ready;

    // A pixel reserves its FIFO slot when its even byte issues, so the odd byte never waits.
    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            S_IDLE: begin
                if (frame_start && ram_ready)
                    state_nxt = S_FETCH;
            end
            S_FETCH: begin
                issue = byte_cnt[0] || (({1'b0, fifo_cnt} + {1'b0, asm_cnt}) < 3'd2);
                if (issue && last_byte)
                    state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (pop && head[17]) begin
                    state_nxt = S_IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            frame_done  <= 1'b0;
            byte_cnt    <= '0;
            pix_cnt     <= '0;
            line_cnt    <= '0;
            rd_vld      <= 1'b0;
            rd_odd      <= 1'b0;
            hi_byte     <= 8'd0;
            asm_cnt     <= 2'd0;
            fifo_mem[0] <= 18'd0;
            fifo_mem[1] <= 18'd0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            fifo_cnt    <= 2'd0;
        end else begin
            state      <= state_nxt;
            frame_done <= done_nxt;
            rd_vld     <= issue;
            rd_odd     <= byte_cnt[0];

            if (start) begin
                byte_cnt <= '0;
                asm_cnt  <= 2'd0;
            end else begin
                if (issue && !last_byte)
                    byte_cnt <= byte_cnt + 1'b1;
                asm_cnt <= asm_cnt + 2'(issue & ~byte_cnt[0]) - 2'(push);
            end

            if (rd_vld && !rd_odd)
                hi_byte <= dataout[7:0];

            if (start) begin
                pix_cnt  <= '0;
                line_cnt <= '0;
            end else if (push) begin
                fifo_mem[wr_ptr] <= {pix_cnt == ADDR_W'(PIXELS - 1),
                                     line_cnt == LW'(LINE_PIXELS - 1),
                                     hi_byte, dataout[7:0]};
                wr_ptr  <= ~wr_ptr;
                pix_cnt <= pix_cnt + 1'b1;
                if (line_cnt == LW'(LINE_PIXELS - 1))
                    line_cnt <= '0;
                else
                    line_cnt <= line_cnt + 1'b1;
            end

            if (pop)
                rd_ptr <= ~rd_ptr;
            fifo_cnt <= fifo_cnt + 2'(push) - 2'(pop);
        end
    end

endmodule

// File: tb/tb_ram_scanout.sv
// tb/tb_ram_scanout.sv - directed self-checking bench for ram_scanout
module tb_ram_scanout;

    localparam int NPIX = 6144;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ram_ready = 1'b0;
    logic        frame_start = 1'b0;
    logic [13:0] address;
    logic [15:0] dataout = 16'd0;
    logic [15:0] px_data;
    logic        px_valid;
    logic        px_ready = 1'b1;
    logic        px_eol;
    logic        px_last;
    logic        busy;
    logic        frame_done;

    int total = 0;
    int bad   = 0;

    int cyc = 0;
    int rdy_mode = 0;
    int pix_cnt, done_cnt, done_cyc, last_hs_cyc, stall_err, done_busy_err;
    logic [15:0] cap_d [NPIX];
    bit          cap_e [NPIX];
    bit          cap_l [NPIX];
    bit          prev_stall;
    logic [17:0] prev_head;

    ram_scanout #(.BYTES(12288), .ADDR_W(14), .LINE_PIXELS(64)) dut (
        .clk(clk), .rst_n(rst_n), .ram_ready(ram_ready), .frame_start(frame_start),
        .address(address), .dataout(dataout), .px_data(px_data), .px_valid(px_valid),
        .px_ready(px_ready), .px_eol(px_eol), .px_last(px_last), .busy(busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // RAM holds mem[i] = i[7:0]; upper lane carries junk that must be ignored.
    always @(posedge clk) dataout <= {8'hA5, address[7:0]};

    always @(negedge clk) begin
        cyc = cyc + 1;
        px_ready = (rdy_mode != 0) ? ($urandom_range(0, 99) < 30) : 1'b1;
        if (frame_done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
            if (busy) done_busy_err = done_busy_err + 1;
        end
        if (prev_stall && (!px_valid || prev_head != {px_last, px_eol, px_data}))
            stall_err = stall_err + 1;
        prev_stall = px_valid && !px_ready;
        prev_head  = {px_last, px_eol, px_data};
        if (px_valid && px_ready) begin
            if (pix_cnt < NPIX) begin
                cap_d[pix_cnt] = px_data;
                cap_e[pix_cnt] = px_eol;
                cap_l[pix_cnt] = px_last;
            end
            if (px_last) last_hs_cyc = cyc;
            pix_cnt = pix_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        pix_cnt = 0; done_cnt = 0; done_cyc = 0; last_hs_cyc = -100;
        stall_err = 0; done_busy_err = 0; prev_stall = 0;
    endtask

    task automatic start_frame(input string tag, output int t0);
        clear_mon();
        @(negedge clk);
        frame_start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        frame_start = 1'b0;
        check({tag, "_busy_up"}, busy, 1);
        check({tag, "_addr0"}, address, 0);
    endtask

    task automatic wait_px(input string tag, input int target);
        int n = 0;
        while (pix_cnt < target && n < 40000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40000) check({tag, "_px_timeout"}, pix_cnt, target);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done_cnt == 0 && n < 40000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done_seen"}, done_cnt, 1);
    endtask

    task automatic verify_frame(input string tag);
        int seq_err = 0, eol_err = 0, last_err = 0;
        logic [15:0] k2;
        repeat (10) @(negedge clk);
        check({tag, "_pix_count"}, pix_cnt, NPIX);
        for (int k = 0; k < NPIX && k < pix_cnt; k++) begin
            k2 = 16'(2 * k);
            if (cap_d[k] !== {k2[7:0], k2[7:0] + 8'd1}) seq_err++;
            if (cap_e[k] !== ((k % 64) == 63)) eol_err++;
            if (cap_l[k] !== (k == NPIX - 1)) last_err++;
        end
        check({tag, "_seq_err"}, seq_err, 0);
        check({tag, "_eol_err"}, eol_err, 0);
        check({tag, "_last_err"}, last_err, 0);
        check({tag, "_px0"}, cap_d[0], 16'h0001);
        check({tag, "_px1"}, cap_d[1], 16'h0203);
        check({tag, "_px127"}, cap_d[127], 16'hFEFF);
        check({tag, "_px128"}, cap_d[128], 16'h0001);
        check({tag, "_px6143"}, cap_d[NPIX-1], 16'hFEFF);
        check({tag, "_done_once"}, done_cnt, 1);
        check({tag, "_done_lat"}, done_cyc - last_hs_cyc, 1);
        check({tag, "_done_busy"}, done_busy_err, 0);
        check({tag, "_stall_err"}, stall_err, 0);
        check({tag, "_idle_after"}, {busy, px_valid}, 2'b00);
    endtask

    initial begin
        int t0;
        int idle_err;
        clear_mon();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("rst_px_valid", px_valid, 0);
        check("rst_px_data", px_data, 0);
        check("rst_flags", {px_eol, px_last, busy, frame_done}, 4'b0000);
        check("rst_address", address, 0);

        // frame_start without ram_ready is dropped and not remembered
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        idle_err = 0;
        repeat (100) begin
            @(negedge clk);
            if (busy || px_valid || address != 14'd0) idle_err++;
        end
        check("idle_hold", idle_err, 0);

        ram_ready = 1'b1;
        start_frame("A", t0);
        wait_done("A");
        check("A_frame_len", (done_cyc - t0) <= 12300, 1);
        verify_frame("A");

        rdy_mode = 1;
        start_frame("B", t0);
        wait_done("B");
        verify_frame("B");
        rdy_mode = 0;

        start_frame("C", t0);
        wait_px("C", 1000);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        wait_done("C");
        verify_frame("C");

        start_frame("D", t0);
        wait_done("D");
        verify_frame("D");

        start_frame("E", t0);
        wait_px("E", 3000);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("E_rst_valid", px_valid, 0);
        check("E_rst_busy", busy, 0);
        repeat (20) @(negedge clk);
        check("E_no_done", done_cnt, 0);

        start_frame("F", t0);
        wait_px("F", 500);
        ram_ready = 1'b0;
        wait_done("F");
        verify_frame("F");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_scanout.md
Name: ram_scanout

Overview:
- Downstream consumer of the ESP-loaded 12 KiB byte RAM.
- After the loader raises ram_ready, it walks the RAM's registered read port once per frame_start request.
- It pairs consecutive bytes into big-endian 16-bit RGB565 pixels and streams them to the LCD writer over a valid/ready interface.
- It flags end-of-line and end-of-frame on the stream.

Parameters:
- BYTES, 12288: bytes scanned per frame (must be even, at most 2**ADDR_W).
- ADDR_W, 14: RAM address width.
- LINE_PIXELS, 64: pixels per line; px_eol asserts on every LINE_PIXELS-th pixel.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- ram_ready  in  1  RAM fully loaded; level
- frame_start  in  1  one-cycle request to scan one frame
- address  out  ADDR_W  RAM byte read address
- dataout  in  16  RAM read data; bits [7:0] valid one cycle after address is presented; bits [15:8] ignored
- px_data  out  16  pixel: {even byte, odd byte}
- px_valid  out  1  pixel valid
- px_ready  in  1  sink accepts pixel when px_valid & px_ready
- px_eol  out  1  qualifies px_data: last pixel of a line
- px_last  out  1  qualifies px_data: last pixel of the frame
- busy  out  1  frame in progress (IDLE -> 0)
- frame_done  out  1  one-cycle pulse after the last pixel handshake

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE, address=0, byte counter=0, pixel counter=0, FIFO emptied, in-flight read dropped. Outputs px_valid=0, px_data=0, px_eol=0, px_last=0, busy=0, frame_done=0. Reset mid-frame aborts the frame with no frame_done.
- State IDLE:
  - frame_start & ram_ready -> FETCH next cycle; byte counter=0, pixel counter=0, busy=1.
  - frame_start while ram_ready=0 is ignored; it is not remembered.
- State FETCH:
  - Read issue: address = byte counter. A read issues in any cycle where credits allow.
  - Data capture: byte captured from dataout[7:0] on the following cycle (1-cycle latency; no read issued in IDLE).
  - Pairing: even-address byte is latched as the high byte. Capturing the odd byte pushes {hi, lo} into a 2-entry output FIFO.
  - Pixel flags: px_eol=1 when (pixel index mod LINE_PIXELS)=LINE_PIXELS-1; px_last=1 for pixel BYTES/2-1.
  - Credit rule: issue only if FIFO occupancy + pixels in assembly < 2. No push ever overflows the FIFO.
  - Throughput: with px_ready held 1, sustained 1 byte/cycle, i.e. 1 pixel per 2 cycles.
  - Exit: after the read of address BYTES-1 issues -> DRAIN.
  - frame_start is ignored while busy.
- State DRAIN:
  - No reads issue; address holds BYTES-1.
  - When the px_last pixel handshakes -> IDLE. frame_done=1 for exactly that next cycle and busy=0 in that same cycle.
- Stream rules:
  - px_valid=1 iff the FIFO is non-empty.
  - px_data, px_eol and px_last are the FIFO head and stay stable while px_valid & ~px_ready.
  - Push and pop in the same cycle are both honoured.
  - px_ready is ignored when px_valid=0.
- ram_ready falling mid-frame is ignored; the frame completes.
- Width rules: byte counter is ADDR_W+1 bits. Pixel counter is ADDR_W bits. Line counter wraps to 0 after LINE_PIXELS-1. No arithmetic wraps within a frame.

Test Plan:
- Reset then ram_ready=0, frame_start pulse -> stays IDLE; busy=0, px_valid=0, address=0 for 100 cycles.
- RAM model filled with mem[i]=i[7:0], ram_ready=1, frame_start, px_ready=1:
  - exactly 6144 pixels; pixel 0=0x0001, pixel 1=0x0203, pixel 127=0xFEFF, pixel 128=0x0001.
  - px_eol on pixels 63, 127, …, 6143; px_last only on pixel 6143.
  - frame_done one cycle after the last handshake; total frame ≤ 12300 cycles.
- Same fill, px_ready random at 30% duty -> identical pixel sequence; no pixel dropped or duplicated; px_data stable during stalls; no address issued while FIFO and assembly credits are full.
- frame_start pulsed again mid-frame (pixel 1000) -> ignored; a single frame of 6144 pixels; a later frame_start in IDLE starts a second frame at address 0.
- rst_n=0 for one cycle at pixel 3000 -> next cycle px_valid=0, busy=0, no frame_done; a subsequent frame_start produces a full, correct frame from pixel 0.
- ram_ready deasserted at pixel 500 -> frame still completes with 6144 pixels and frame_done.
